// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches a one-hot ring counter. It encodes the sampled vector to a binary
//   phase index, checks that each sample is one-hot and that the ring steps by
//   rotate-left, and counts full revolutions. Errors are reported as 1-cycle
//   pulses, as a sticky flag and as a saturating error count.
//
//   Optional feature macro: RING_MON_HOLD_EN
//     defined   - in TRACK, a sample equal to the previous one is legal and
//                 changes nothing (suits a clock-enabled ring counter).
//     undefined - in TRACK, a sample equal to the previous one is a step error.
//
//   Reset is asynchronous and active-low, on the port named rst.

module ring_phase_monitor #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8,
    parameter int ERR_W = 4,
    localparam int PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_vld,
    input  logic             src_sync,
    input  logic             clr_err,
    output logic [PW-1:0]    phase,
    output logic             phase_vld,
    output logic             wrap,
    output logic [REV_W-1:0] rev_cnt,
    output logic             onehot_err,
    output logic             step_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);
    localparam logic [WIDTH-1:0] VEC_ONE = WIDTH'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] prev_reg;

    // Decoded view of the current sample relative to the stored one.
    logic [PW-1:0]    sample_idx;
    logic [WIDTH-1:0] prev_rotl;
    logic             sample_onehot;
    logic             sample_is_step;
    logic             sample_is_hold;
    logic             sample_is_wrap;
    logic             take_sample;
    logic             onehot_hit;
    logic             step_hit;
    logic             err_hit;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign sample_onehot = (ring_in != '0) &&
                           ((ring_in & (ring_in - VEC_ONE)) == '0);

    assign prev_rotl = {prev_reg[WIDTH-2:0], prev_reg[WIDTH-1]};

    // One-hot to binary: index bit b is the OR of every ring bit whose
    // position has bit b set. Only meaningful when the sample is one-hot.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_idx_bit
            logic [WIDTH-1:0] sel;
            for (genvar gj = 0; gj < WIDTH; gj++) begin : g_idx_sel
                if (((gj >> gi) & 1) != 0) begin : g_on
                    assign sel[gj] = ring_in[gj];
                end else begin : g_off
                    assign sel[gj] = 1'b0;
                end
            end
            assign sample_idx[gi] = |sel;
        end
    endgenerate

    // src_sync overrides any same-cycle sample, so it gates every event.
    assign take_sample    = ring_vld && !src_sync;
    assign sample_is_step = (ring_in == prev_rotl);
    assign sample_is_wrap = sample_is_step && prev_reg[WIDTH-1];

`ifdef RING_MON_HOLD_EN
    assign sample_is_hold = (ring_in == prev_reg);
`else
    assign sample_is_hold = 1'b0;
`endif

    // Classify the sample into the two error kinds; they are mutually exclusive.
    always_comb begin
        onehot_hit = 1'b0;
        step_hit   = 1'b0;
        if (take_sample) begin
            if (!sample_onehot) begin
                onehot_hit = 1'b1;
            end else if (state_reg == ST_TRACK && !sample_is_step && !sample_is_hold) begin
                step_hit = 1'b1;
            end
        end
    end

    assign err_hit = onehot_hit || step_hit;

    // Tracking FSM: state, stored sample, phase and the per-sample pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_ACQ;
            prev_reg   <= '0;
            phase      <= '0;
            phase_vld  <= 1'b0;
            wrap       <= 1'b0;
            rev_cnt    <= '0;
            onehot_err <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            wrap       <= 1'b0;
            onehot_err <= onehot_hit;
            step_err   <= step_hit;
            if (src_sync) begin
                // Upstream ring is being reset: drop lock quietly.
                state_reg <= ST_ACQ;
                prev_reg  <= '0;
                phase_vld <= 1'b0;
            end else if (ring_vld) begin
                case (state_reg)
                    ST_ACQ: begin
                        if (sample_onehot) begin
                            state_reg <= ST_TRACK;
                            prev_reg  <= ring_in;
                            phase     <= sample_idx;
                            phase_vld <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (!sample_onehot) begin
                            // Lost the ring; phase keeps the last legal index.
                            state_reg <= ST_ACQ;
                            phase_vld <= 1'b0;
                        end else if (sample_is_step) begin
                            prev_reg <= ring_in;
                            phase    <= sample_idx;
                            if (sample_is_wrap) begin
                                wrap    <= 1'b1;
                                rev_cnt <= rev_cnt + REV_ONE;
                            end
                        end else if (!sample_is_hold) begin
                            // Unexpected but legal vector: re-lock onto it.
                            prev_reg <= ring_in;
                            phase    <= sample_idx;
                        end
                    end
                    default: begin
                        state_reg <= ST_ACQ;
                        phase_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Error accounting: an error in the same cycle as clr_err takes precedence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_hit) begin
            err_sticky <= 1'b1;
            if (clr_err) begin
                err_cnt <= ERR_ONE;
            end else if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_ONE;
            end
        end else if (clr_err) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end
    end

endmodule
